// File: rtl/sound_pkg.sv
// Shared types and constants for the sound mixer: FSM encoding, channel count,
// datapath widths and the per-channel gated multiply.
package sound_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_e;

  localparam int NUM_CH   = 10;
  localparam int MIDPOINT = 128;
  localparam int ACC_W    = 16;
  localparam int IDX_W    = 4;

  // Offset-binary sample times unsigned gain; silent when gain or data is zero.
  function automatic logic signed [ACC_W-1:0] chan_term(input logic [7:0] data,
                                                         input logic [3:0] amp);
    logic signed [8:0]  s;
    logic signed [13:0] p;
    s = $signed({1'b0, data}) - $signed(9'(MIDPOINT));
    p = s * $signed({1'b0, amp});
    if (amp == 4'd0 || data == 8'h00) begin
      return '0;
    end
    return ACC_W'(p);
  endfunction

endpackage

// File: rtl/sound_pwm.sv
// Free-running 8-bit PWM: output is high while the counter is below the level.
module sound_pwm (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] level,
  output logic       pwm_out
);

  logic [7:0] cnt_q;
  logic       pwm_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_q <= 8'd0;
      pwm_q <= 1'b0;
    end else begin
      cnt_q <= cnt_q + 8'd1;
      pwm_q <= (cnt_q < level);
    end
  end

  assign pwm_out = pwm_q;

endmodule

// File: rtl/sound_mixer.sv
// Ten-channel sample mixer: snapshots all channels on sample_tick, runs one
// signed MAC per clock, saturates to 8-bit offset-binary and drives a PWM pin.
// Handshake: sample_tick is accepted only in IDLE; a tick while busy is dropped
// and flagged on overrun for one cycle; sample_valid pulses once per accepted tick.
module sound_mixer
  import sound_pkg::*;
#(
  parameter int SHIFT = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sample_tick,
  input  logic [7:0] bground,
  input  logic [3:0] bamp,
  input  logic [7:0] sfx0,
  input  logic [7:0] sfx1,
  input  logic [7:0] sfx2,
  input  logic [7:0] sfx3,
  input  logic [7:0] sfx4,
  input  logic [7:0] sfx5,
  input  logic [7:0] sfx6,
  input  logic [7:0] sfx7,
  input  logic [7:0] sfx8,
  input  logic [3:0] sfx_amp0,
  input  logic [3:0] sfx_amp1,
  input  logic [3:0] sfx_amp2,
  input  logic [3:0] sfx_amp3,
  input  logic [3:0] sfx_amp4,
  input  logic [3:0] sfx_amp5,
  input  logic [3:0] sfx_amp6,
  input  logic [3:0] sfx_amp7,
  input  logic [3:0] sfx_amp8,
  output logic [7:0] sample_out,
  output logic       sample_valid,
  output logic       busy,
  output logic       overrun,
  output logic       pwm_out
);

  state_e                  state_q, state_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic [7:0]              sample_q, sample_d;
  logic                    valid_q, overrun_q;
  logic [7:0]              data_q [NUM_CH];
  logic [3:0]              amp_q  [NUM_CH];
  logic [7:0]              in_data [NUM_CH];
  logic [3:0]              in_amp  [NUM_CH];

  logic                    load;
  logic                    accum;
  logic                    finish;
  logic signed [ACC_W-1:0] cur_term;
  logic signed [ACC_W-1:0] shifted;
  logic [7:0]              sat;

  // Channel 0 is the background; 1..9 are the effect channels.
  assign in_data = '{bground, sfx0, sfx1, sfx2, sfx3, sfx4, sfx5, sfx6, sfx7, sfx8};
  assign in_amp  = '{bamp, sfx_amp0, sfx_amp1, sfx_amp2, sfx_amp3,
                     sfx_amp4, sfx_amp5, sfx_amp6, sfx_amp7, sfx_amp8};

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      acc_q     <= '0;
      sample_q  <= 8'(MIDPOINT);
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
      for (int i = 0; i < NUM_CH; i++) begin
        data_q[i] <= 8'h00;
        amp_q[i]  <= 4'h0;
      end
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      acc_q     <= acc_d;
      sample_q  <= sample_d;
      valid_q   <= finish;
      overrun_q <= sample_tick && (state_q != IDLE);
      if (load) begin
        for (int i = 0; i < NUM_CH; i++) begin
          data_q[i] <= in_data[i];
          amp_q[i]  <= in_amp[i];
        end
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (sample_tick) state_d = ACCUM;
      ACCUM:   if (idx_q == IDX_W'(NUM_CH - 1)) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    load   = (state_q == IDLE) && sample_tick;
    accum  = (state_q == ACCUM);
    finish = (state_q == DONE);
    busy   = (state_q != IDLE);
  end

  always_comb begin
    cur_term = chan_term(data_q[idx_q], amp_q[idx_q]);
    shifted  = acc_q >>> SHIFT;
    if (shifted > 16'sd127) begin
      sat = 8'hFF;
    end else if (shifted < -16'sd128) begin
      sat = 8'h00;
    end else begin
      sat = {~shifted[7], shifted[6:0]};
    end
  end

  always_comb begin
    idx_d    = idx_q;
    acc_d    = acc_q;
    sample_d = sample_q;
    if (load) begin
      idx_d = '0;
      acc_d = '0;
    end else if (accum) begin
      idx_d = idx_q + IDX_W'(1);
      acc_d = acc_q + cur_term;
    end else if (finish) begin
      sample_d = sat;
    end
  end

  assign sample_out   = sample_q;
  assign sample_valid = valid_q;
  assign overrun      = overrun_q;

  sound_pwm u_pwm (
    .clk     (clk),
    .rst     (rst),
    .level   (sample_q),
    .pwm_out (pwm_out)
  );

endmodule

// File: tb/tb_sound_mixer.sv
// Directed bench for sound_mixer: a table of single-mix vectors plus hand
// sequences for reset, PWM duty, overrun/snapshot and reset mid-mix.
module tb_sound_mixer;

  logic       clk;
  logic       rst;
  logic       sample_tick;
  logic [7:0] bground;
  logic [3:0] bamp;
  logic [7:0] sfx [9];
  logic [3:0] sfx_amp [9];
  logic [7:0] sample_out;
  logic       sample_valid;
  logic       busy;
  logic       overrun;
  logic       pwm_out;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [7:0]      bground;
    logic [3:0]      bamp;
    logic [8:0][7:0] sfx;
    logic [8:0][3:0] amp;
    logic [7:0]      exp_out;
  } vec_t;

  vec_t vecs [10];

  sound_mixer #(.SHIFT(3)) dut (
    .clk(clk), .rst(rst), .sample_tick(sample_tick),
    .bground(bground), .bamp(bamp),
    .sfx0(sfx[0]), .sfx1(sfx[1]), .sfx2(sfx[2]), .sfx3(sfx[3]), .sfx4(sfx[4]),
    .sfx5(sfx[5]), .sfx6(sfx[6]), .sfx7(sfx[7]), .sfx8(sfx[8]),
    .sfx_amp0(sfx_amp[0]), .sfx_amp1(sfx_amp[1]), .sfx_amp2(sfx_amp[2]),
    .sfx_amp3(sfx_amp[3]), .sfx_amp4(sfx_amp[4]), .sfx_amp5(sfx_amp[5]),
    .sfx_amp6(sfx_amp[6]), .sfx_amp7(sfx_amp[7]), .sfx_amp8(sfx_amp[8]),
    .sample_out(sample_out), .sample_valid(sample_valid), .busy(busy),
    .overrun(overrun), .pwm_out(pwm_out)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Driver tasks
  task automatic drive_vec(input vec_t v);
    bground = v.bground;
    bamp    = v.bamp;
    for (int i = 0; i < 9; i++) begin
      sfx[i]     = v.sfx[i];
      sfx_amp[i] = v.amp[i];
    end
  endtask

  function automatic vec_t mk(input logic [7:0] bg, input logic [3:0] ba,
                              input logic [7:0] exp_out);
    vec_t v;
    v.bground = bg;
    v.bamp    = ba;
    v.sfx     = '0;
    v.amp     = '0;
    v.exp_out = exp_out;
    return v;
  endfunction

  // Edge 0 is the tick edge; busy through edge 10, valid and result on edge 11.
  task automatic run_mix(input vec_t v, input string name);
    int bad_busy;
    drive_vec(v);
    sample_tick = 1'b1;
    cycle();
    sample_tick = 1'b0;
    bad_busy = 0;
    for (int e = 1; e <= 10; e++) begin
      cycle();
      if (busy !== 1'b1 || sample_valid !== 1'b0) bad_busy++;
    end
    check({name, " busy/no-valid edges 1..10"}, bad_busy, 0);
    cycle();
    check({name, " sample_valid"}, sample_valid, 1);
    check({name, " busy cleared"}, busy, 0);
    check({name, " sample_out"}, sample_out, v.exp_out);
    cycle();
    check({name, " valid one cycle"}, sample_valid, 0);
  endtask

  task automatic pwm_duty(input string name, input int exp_high);
    int high;
    high = 0;
    for (int i = 0; i < 256; i++) begin
      cycle();
      if (pwm_out === 1'b1) high++;
    end
    check(name, high, exp_high);
  endtask

  initial begin
    int ovr_cnt;
    int val_cnt;
    vec_t v;

    rst = 1'b0;
    sample_tick = 1'b0;
    drive_vec('0);

    // Table: hand-computed results for SHIFT=3.
    vecs[0] = mk(8'hFF, 4'd8, 8'hFF);              // 127*8=1016 -> 127
    vecs[1] = mk(8'h40, 4'd4, 8'h60);              // -256 -> -32
    vecs[2] = mk(8'hFF, 4'd15, 8'hFF);
    vecs[2].sfx = {9{8'hFF}};
    vecs[2].amp = {9{4'd15}};                      // 19050 -> clip 127
    vecs[3] = mk(8'h01, 4'd15, 8'h00);
    vecs[3].sfx = {9{8'h01}};
    vecs[3].amp = {9{4'd15}};                      // -19050 -> clip -128
    vecs[4] = mk(8'h7F, 4'd1, 8'h7F);              // -1 >>> 3 = -1 (floor)
    vecs[5] = mk(8'hC0, 4'd3, 8'h94);              // 192-192+160=160 -> 20
    vecs[5].sfx[0] = 8'h20; vecs[5].amp[0] = 4'd2;
    vecs[5].sfx[1] = 8'hA0; vecs[5].amp[1] = 4'd5;
    vecs[5].sfx[2] = 8'h00; vecs[5].amp[2] = 4'd15;
    vecs[6] = mk(8'hFF, 4'd0, 8'h8F);              // bground gated by amp 0
    vecs[6].sfx[8] = 8'hFF; vecs[6].amp[8] = 4'd1; // 127 -> 15
    vecs[7] = mk(8'h80, 4'd15, 8'h01);
    vecs[7].sfx[5] = 8'h01; vecs[7].amp[5] = 4'd8; // -1016 -> -127
    vecs[8] = mk(8'h00, 4'd15, 8'h90);             // bground gated by data 0
    vecs[8].sfx[3] = 8'h90; vecs[8].amp[3] = 4'd15;
    vecs[8].sfx[6] = 8'h70; vecs[8].amp[6] = 4'd7; // 240-112=128 -> 16
    vecs[9] = mk(8'h00, 4'd0, 8'h80);              // all inactive

    // Reset state and PWM at the midpoint level
    cycle();
    cycle();
    check("reset sample_out", sample_out, 8'h80);
    check("reset busy", busy, 0);
    check("reset sample_valid", sample_valid, 0);
    check("reset overrun", overrun, 0);
    check("reset pwm_out", pwm_out, 0);
    rst = 1'b1;
    pwm_duty("pwm duty at 0x80", 128);

    for (int i = 0; i < 10; i++) begin
      run_mix(vecs[i], $sformatf("vec%0d", i));
    end

    // PWM extremes
    run_mix(vecs[0], "pwm full");
    pwm_duty("pwm duty at 0xFF", 255);
    run_mix(vecs[3], "pwm zero");
    pwm_duty("pwm duty at 0x00", 0);

    // Overrun, gating and snapshot: leave sample_out at 0xFF first.
    run_mix(vecs[0], "pre-overrun");
    v = mk(8'h80, 4'd4, 8'h80);
    v.sfx[3] = 8'h00;
    v.amp[3] = 4'd15;
    drive_vec(v);
    ovr_cnt = 0;
    val_cnt = 0;
    sample_tick = 1'b1;
    cycle();                       // edge 0
    sample_tick = 1'b0;
    for (int e = 1; e <= 16; e++) begin
      if (e == 2) bground = 8'hFF;
      if (e == 5) sample_tick = 1'b1;
      cycle();
      sample_tick = 1'b0;
      if (overrun === 1'b1) ovr_cnt++;
      if (sample_valid === 1'b1) val_cnt++;
      if (e == 11) check("snapshot sample_out", sample_out, 8'h80);
    end
    check("overrun pulse count", ovr_cnt, 1);
    check("single sample_valid", val_cnt, 1);
    check("idle after overrun", busy, 0);

    // Reset mid-mix: sample_out is 0x80, so push it away first.
    run_mix(vecs[0], "pre-reset");
    drive_vec(vecs[1]);
    val_cnt = 0;
    sample_tick = 1'b1;
    cycle();                       // edge 0
    sample_tick = 1'b0;
    for (int e = 1; e <= 5; e++) begin
      cycle();
      if (sample_valid === 1'b1) val_cnt++;
    end
    rst = 1'b0;
    cycle();                       // edge 6 with reset
    check("midreset busy", busy, 0);
    check("midreset sample_out", sample_out, 8'h80);
    rst = 1'b1;
    for (int e = 0; e < 12; e++) begin
      cycle();
      if (sample_valid === 1'b1) val_cnt++;
    end
    check("midreset no sample_valid", val_cnt, 0);
    check("midreset sample_out held", sample_out, 8'h80);
    run_mix(vecs[5], "post-reset mix");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sound_mixer.md
Name: sound_mixer

Overview:
- Downstream stage of sound_controller.
- Consumes the background channel (bground/bamp) and nine effect channels (sfx0..sfx8 / sfx_amp0..sfx_amp8).
- On each sample tick, snapshots all ten channels, then time-multiplexes one signed multiply-accumulate per clock.
- Saturates the sum to an 8-bit offset-binary sample and drives a free-running 8-bit PWM audio pin.

Parameters:
SHIFT, 3, arithmetic right-shift applied to the 16-bit accumulator before saturation (master gain)

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-low reset
sample_tick  in  1  one-cycle pulse at audio sample rate; starts a mix
bground  in  8  background sample, offset-binary (0x80 = zero)
bamp  in  4  background gain 0..15
sfx0..sfx8  in  8 each  effect samples, offset-binary; 0x00 means channel inactive
sfx_amp0..sfx_amp8  in  4 each  effect gains 0..15
sample_out  out  8  last mixed sample, offset-binary
sample_valid  out  1  one-cycle pulse when sample_out updates
busy  out  1  high while a mix is in progress
overrun  out  1  one-cycle pulse when sample_tick arrives while busy
pwm_out  out  1  PWM audio output

Behaviour:
- Reset values:
  - sample_out = 8'h80; sample_valid = 0; busy = 0; overrun = 0; pwm_out = 0.
  - PWM counter = 0; accumulator = 0; state = IDLE.
- Reset wins over every other event.
- Reset mid-mix aborts the mix: no sample_valid, and sample_out returns to 8'h80.
- States are IDLE, ACCUM and DONE.
  - IDLE: sample_tick=1 at an edge does three things: registers all 20 data/amp inputs into a snapshot bank, clears acc, and sets idx=0. State goes to ACCUM and busy goes to 1.
  - ACCUM: each edge adds the term for channel idx (0 = background, 1..9 = sfx0..sfx8), then increments idx. After the idx=9 add, state goes to DONE.
  - DONE: one edge writes sample_out, pulses sample_valid, sets busy to 0 and returns to IDLE.
- Latency: the tick edge is edge 0. Channels accumulate on edges 1..10. sample_out/sample_valid update on edge 11. Back-to-back mixes are possible every 12 cycles.
- Input changes after edge 0 do not affect the current mix.
- sample_tick in ACCUM or DONE is ignored. It pulses overrun for 1 cycle and does not restart the mix.
- Per-channel term:
  - s = {1'b0,data} − 128, a 9-bit signed value in the range −128..127.
  - term = s × amp, a 13-bit signed value in the range −1920..1905.
  - term is forced to 0 when amp = 0 or data = 8'h00 (inactive gating).
  - Background is gated the same way.
- Accumulator is 16-bit signed. Worst case is ±19200, so it never overflows.
- Result:
  - r = acc >>> SHIFT (arithmetic, floor).
  - Clip r to [−128, 127].
  - sample_out = r + 128, truncated to 8 bits.
- PWM:
  - 8-bit counter increments every clk and wraps 255→0.
  - pwm_out is registered, = (cnt < sample_out).
  - sample_out = 0 gives constant 0; 255 gives 255/256 duty.
  - The counter is not resynchronised by sample updates; a new value takes effect at the next compare.

Decomposition:
- Package sound_pkg holds:
  - state enum {IDLE, ACCUM, DONE};
  - NUM_CH = 10;
  - MIDPOINT = 128;
  - accumulator width 16;
  - channel index width 4.
- One sub-module, sound_pwm:
  - ports clk, rst, level[7:0], pwm_out;
  - contains the counter and the comparator.
- The MAC datapath and FSM stay in sound_mixer.

Test Plan:
- Reset:
  - stimulus: rst=0 for 2 cycles, then release;
  - required: sample_out=8'h80, busy=0, pwm_out high for exactly 128 of every 256 cycles.
- Single channel full scale:
  - stimulus: bground=8'hFF, bamp=8, all sfx=0, tick;
  - required: busy=1 on edges 1..10, sample_valid on edge 11, sample_out=8'hFF (127·8>>>3=127).
- Negative value:
  - stimulus: bground=8'h40, bamp=4, others inactive, tick;
  - required: sample_out=8'h60 (−256>>>3=−32).
- Saturation, positive:
  - stimulus: all ten channels data 8'hFF, amp 15, tick;
  - required: sample_out=8'hFF (19050>>>3=2381, clipped).
- Saturation, negative:
  - stimulus: all ten channels data 8'h01, amp 15, tick;
  - required: sample_out=8'h00 (−2382 clipped to −128).
- Gating, overrun and snapshot:
  - stimulus: sfx3=8'h00 with sfx_amp3=15, bground=8'h80; tick; second tick 5 cycles later;
  - stimulus: change bground to 8'hFF on edge 2;
  - required: one overrun pulse and a single sample_valid, with sample_out=8'h80.
- Reset mid-mix:
  - stimulus: assert rst at edge 6 of a mix;
  - required: no sample_valid; busy=0 and sample_out=8'h80 after the reset edge; next tick mixes normally.
